dc_data_array_param: RTL
========================

DC_DATA_ARRAY_PARAM -- requirements
Module: dc_data_array_param

Interface
REQ-001 SHALL have parameter WAYS, default 2: number of ways, 1..8.
REQ-002 SHALL have parameter SETS, default 16: sets per way, a power of 2, at least 2.
REQ-003 SHALL have parameter LINE_BYTES, default 16: bytes per line, a power of 2.
REQ-004 SHALL have parameter FILL_BYTES, default 4: bytes per fill beat; must divide LINE_BYTES.
REQ-005 SHALL have ports, derived widths IW=log2(SETS), WW=log2(WAYS), LW=LINE_BYTES*8:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  array accepts core writes and fill starts.
- rd_en  in  1  read request.
- rd_index  in  IW  read set.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  WAYS*LW  all ways of the set; way w occupies bits [w*LW +: LW].
- wr_en  in  1  core write request.
- wr_index  in  IW  write set.
- wr_way  in  WW  write way.
- wr_mask  in  LINE_BYTES  byte enables.
- wr_data  in  LW  write data.
- fill_start  in  1  begin a line fill.
- fill_index  in  IW  fill set.
- fill_way  in  WW  fill way.
- fill_valid  in  1  fill beat present.
- fill_data  in  FILL_BYTES*8  beat data.
- fill_done  out  1  one-cycle pulse when the fill is complete.

Function
REQ-006 SHALL implement FSM states INIT, RUN and FILL.
REQ-007 INIT SHALL zero one set, across all ways, per cycle, starting at set 0 and incrementing; after set SETS-1 it SHALL enter RUN, so INIT lasts exactly SETS cycles.
REQ-008 ready SHALL be 1 only in RUN.
REQ-009 In INIT, rd_en, wr_en and fill_start SHALL be ignored.
REQ-010 Reads SHALL be served in RUN and FILL with a registered read: rd_valid and rd_data appear the cycle after rd_en and hold for one cycle only.
REQ-011 In RUN, a write with wr_en=1 SHALL update only the bytes whose wr_mask bit is 1, in way wr_way of set wr_index, at the clock edge.
REQ-012 On a same-cycle read and write to the same index, the returned data SHALL be the post-write contents (write-first forwarding), merged per byte.
REQ-013 wr_en SHALL be ignored in FILL.
REQ-014 fill_start in RUN SHALL latch fill_index and fill_way, clear the beat counter and enter FILL.
REQ-015 If fill_start and wr_en are both high in RUN, the write SHALL be performed and the fill SHALL also start.
REQ-016 In FILL, each cycle with fill_valid=1 SHALL write fill_data into bytes [beat*FILL_BYTES +: FILL_BYTES] of the latched line and increment the beat counter; cycles with fill_valid=0 SHALL make no change.
REQ-017 After beat LINE_BYTES/FILL_BYTES-1 is written, the block SHALL pulse fill_done for the next cycle and return to RUN in that same cycle.
REQ-018 fill_start during FILL SHALL be ignored.
REQ-019 Forwarding per REQ-012 SHALL also apply to a fill beat whose target is the set being read.
REQ-020 The beat counter SHALL be log2(LINE_BYTES/FILL_BYTES) bits wide (minimum 1) and wraps only by returning to RUN.

Reset
REQ-021 While rst=1 at a clock edge, the FSM SHALL go to INIT with the set counter at 0, and rd_valid, fill_done and ready SHALL be 0.
REQ-022 rst asserted mid-FILL SHALL abort the fill with no fill_done pulse; the array is then fully re-zeroed by INIT.
REQ-023 Array contents SHALL be reported only through reads; after INIT every byte reads as 0.

Structure
REQ-024 Package dc_pkg SHALL hold the FSM state enum and the default WAYS, SETS, LINE_BYTES and FILL_BYTES constants.
REQ-025 The storage of one way SHALL be the sub-module dc_way_bank: SETS x LINE_BYTES, with a byte write mask, a synchronous write port and an asynchronous read port; it is instantiated WAYS times.
REQ-026 Read registering, forwarding and the FSM SHALL reside in the top-level module.

Verification
REQ-027 Reset: assert rst 1 cycle, then release -> ready=0 for 16 cycles, ready=1 at cycle 17; reading sets 0..15 returns all-zero.
REQ-028 Masked write: write way1, set 5, mask 16'h00F0, data all 8'hAA, then read set 5 -> way1 bytes 4..7 = AA, all other bytes 0, rd_valid one cycle after rd_en.
REQ-029 Collision: same cycle rd_en + wr_en, set 3, way0, mask 16'h0001, data byte 8'h5C -> next-cycle rd_data way0 byte0 = 5C.
REQ-030 Fill: fill_start set 9, way0, with 4 beats 11111111, 22222222, 33333333, 44444444 separated by one idle cycle each -> fill_done 1 cycle after beat 4, ready returns, line reads back in beat order, wr_en during the fill is ignored.
REQ-031 Reset mid-fill: rst after beat 2 -> no fill_done pulse, 16-cycle INIT, set 9 reads 0.

Source files
------------

// File: rtl/dc_pkg.sv
// Shared definitions for the parameterised data-cache data array.
//   dc_state_e     : controller state encoding (INIT / RUN / FILL)
//   DC_*           : default geometry of the array
//   dc_clog2_min1  : log2 that never returns a zero width
package dc_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_FILL = 2'd2
   } dc_state_e;

   localparam int DC_WAYS       = 2;
   localparam int DC_SETS       = 16;
   localparam int DC_LINE_BYTES = 16;
   localparam int DC_FILL_BYTES = 4;

   function automatic int dc_clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dc_way_bank.sv
// Storage for one way of the data array: SETS lines of LINE_BYTES bytes.
// Ports:
//   clk_i        clock, write happens on the rising edge
//   we_i         write enable
//   wr_index_i   set written
//   wr_mask_i    per-byte write enables
//   wr_data_i    full-line write data (only masked bytes land)
//   rd_index_i   set read (combinational read)
//   rd_data_o    contents of set rd_index_i
module dc_way_bank #(
   parameter  int SETS       = 16,
   parameter  int LINE_BYTES = 16,
   localparam int IW         = $clog2(SETS),
   localparam int LW         = LINE_BYTES * 8
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [IW-1:0]         wr_index_i,
   input  logic [LINE_BYTES-1:0] wr_mask_i,
   input  logic [LW-1:0]         wr_data_i,
   input  logic [IW-1:0]         rd_index_i,
   output logic [LW-1:0]         rd_data_o
);

   logic [LW-1:0] mem_q [SETS];

   // No reset: the controller clears every line during INIT.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < LINE_BYTES; b++) begin
            if (wr_mask_i[b]) begin
               mem_q[wr_index_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
            end
         end
      end
   end

   assign rd_data_o = mem_q[rd_index_i];

endmodule

// File: rtl/dc_data_array_param.sv
// Parameterised data-cache data array: WAYS banks of SETS lines, a registered
// all-ways read port with write-first forwarding, a masked core write port and
// a beat-wise line fill engine. After reset the array zeroes itself one set per
// cycle before accepting traffic.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ready                            high only while idle in RUN
//   rd_en, rd_index                  read request (all ways of one set)
//   rd_valid, rd_data                registered read response, one cycle later
//   wr_en, wr_index, wr_way,
//   wr_mask, wr_data                 core write (RUN only)
//   fill_start, fill_index, fill_way begin a line fill (RUN only)
//   fill_valid, fill_data            fill beats (FILL only)
//   fill_done                        one-cycle pulse after the last beat
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | zeroing set init_cnt_q across all ways, one set per cycle
// ST_RUN  | idle; serves reads, core writes and fill starts
// ST_FILL | writing fill beats into the latched line; reads still served
module dc_data_array_param
   import dc_pkg::*;
#(
   parameter  int WAYS       = DC_WAYS,
   parameter  int SETS       = DC_SETS,
   parameter  int LINE_BYTES = DC_LINE_BYTES,
   parameter  int FILL_BYTES = DC_FILL_BYTES,
   localparam int IW         = $clog2(SETS),
   localparam int WW         = dc_clog2_min1(WAYS),
   localparam int LW         = LINE_BYTES * 8,
   localparam int FW         = FILL_BYTES * 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready,
   input  logic                  rd_en,
   input  logic [IW-1:0]         rd_index,
   output logic                  rd_valid,
   output logic [WAYS*LW-1:0]    rd_data,
   input  logic                  wr_en,
   input  logic [IW-1:0]         wr_index,
   input  logic [WW-1:0]         wr_way,
   input  logic [LINE_BYTES-1:0] wr_mask,
   input  logic [LW-1:0]         wr_data,
   input  logic                  fill_start,
   input  logic [IW-1:0]         fill_index,
   input  logic [WW-1:0]         fill_way,
   input  logic                  fill_valid,
   input  logic [FW-1:0]         fill_data,
   output logic                  fill_done
);

   localparam int NB = LINE_BYTES / FILL_BYTES;
   localparam int BW = dc_clog2_min1(NB);

   typedef logic [WAYS-1:0][LW-1:0] line_set_t;

   dc_state_e        state_q;
   logic [IW-1:0]    init_cnt_q;
   logic [BW-1:0]    beat_q;
   logic [IW-1:0]    fill_index_q;
   logic [WW-1:0]    fill_way_q;
   logic             fill_done_q;
   logic             rd_valid_q;
   line_set_t        rd_data_q;
   line_set_t        rd_data_d;

   logic [WAYS-1:0]       bank_we;
   logic [IW-1:0]         bank_idx;
   logic [LINE_BYTES-1:0] bank_mask;
   logic [LW-1:0]         bank_wdata;
   line_set_t             bank_rdata;

   // Single shared write port: INIT, core writes and fill beats are mutually
   // exclusive by state, so one index/mask/data bus feeds every bank and only
   // the per-way enable differs.
   always_comb begin
      bank_we    = '0;
      bank_idx   = wr_index;
      bank_mask  = '0;
      bank_wdata = '0;
      unique case (state_q)
         ST_INIT: begin
            bank_we   = '1;
            bank_idx  = init_cnt_q;
            bank_mask = '1;
         end
         ST_RUN: begin
            if (wr_en) begin
               bank_idx   = wr_index;
               bank_mask  = wr_mask;
               bank_wdata = wr_data;
               for (int w = 0; w < WAYS; w++) begin
                  if (int'(wr_way) == w) bank_we[w] = 1'b1;
               end
            end
         end
         ST_FILL: begin
            if (fill_valid) begin
               bank_idx   = fill_index_q;
               bank_wdata = {NB{fill_data}};
               for (int b = 0; b < LINE_BYTES; b++) begin
                  bank_mask[b] = ((b / FILL_BYTES) == int'(beat_q));
               end
               for (int w = 0; w < WAYS; w++) begin
                  if (int'(fill_way_q) == w) bank_we[w] = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      dc_way_bank #(
         .SETS       (SETS),
         .LINE_BYTES (LINE_BYTES)
      ) u_bank (
         .clk_i      (clk),
         .we_i       (bank_we[w]),
         .wr_index_i (bank_idx),
         .wr_mask_i  (bank_mask),
         .wr_data_i  (bank_wdata),
         .rd_index_i (rd_index),
         .rd_data_o  (bank_rdata[w])
      );
   end

   // Write-first: bytes being written this edge to the set being read are
   // taken from the write bus instead of the (still old) bank contents.
   always_comb begin
      rd_data_d = bank_rdata;
      for (int w = 0; w < WAYS; w++) begin
         if (bank_we[w] && (bank_idx == rd_index)) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
               if (bank_mask[b]) rd_data_d[w][b*8 +: 8] = bank_wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_INIT;
         init_cnt_q   <= '0;
         beat_q       <= '0;
         fill_index_q <= '0;
         fill_way_q   <= '0;
         fill_done_q  <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         fill_done_q <= 1'b0;
         rd_valid_q  <= rd_en && (state_q != ST_INIT);
         if (rd_en && (state_q != ST_INIT)) rd_data_q <= rd_data_d;

         unique case (state_q)
            ST_INIT: begin
               init_cnt_q <= init_cnt_q + 1'b1;
               if (init_cnt_q == IW'(SETS - 1)) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (fill_start) begin
                  fill_index_q <= fill_index;
                  fill_way_q   <= fill_way;
                  beat_q       <= '0;
                  state_q      <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (fill_valid) begin
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == BW'(NB - 1)) begin
                     fill_done_q <= 1'b1;
                     state_q     <= ST_RUN;
                  end
               end
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   assign ready     = (state_q == ST_RUN);
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign fill_done = fill_done_q;

endmodule
